// File: rtl/instr_decode_stage.sv
// Registered instruction decode stage: one-hot control vector, register fields, sticky halt.
// Optional macro DEC_ILLEGAL_TRAP_EN: illegal encodings trap instead of decoding as NOP.
module instr_decode_stage #(
    parameter int IR_W = 8,
    parameter int RF_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IR_W-1:0] ir,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     op,
    output logic [RF_W-1:0] r1,
    output logic [RF_W-1:0] r2,
    output logic            illegal,
    output logic            halted
);

    localparam logic [RF_W-1:0] ONES = '1;

`ifdef DEC_ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALTED  = 2'd1,
        TRAPPED = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1
    } state_t;
`endif

    state_t state_q, state_d;

    logic [3:0]      opc;
    logic [RF_W-1:0] f1;
    logic [RF_W-1:0] f2;
    logic [15:0]     dec_op;
    logic            dec_bad;
    logic [15:0]     nxt_op;
    logic            nxt_ill;
    logic            accept;

    assign opc = ir[IR_W-1 -: 4];
    assign f1  = ir[2*RF_W-1 -: RF_W];
    assign f2  = ir[RF_W-1:0];

    generate
        if (IR_W > 4 + 2*RF_W) begin : g_mid
            logic unused_mid;
            assign unused_mid = ^ir[IR_W-5:2*RF_W];
        end
    endgenerate

    always_comb begin
        dec_op  = '0;
        dec_bad = 1'b0;
        unique case (opc)
            4'b1100: begin
                if (f2 == ONES)      dec_op[2] = 1'b1;
                else if (f1 == ONES) dec_op[1] = 1'b1;
                else                 dec_op[0] = 1'b1;
            end
            4'b1001: dec_op[3] = 1'b1;
            4'b0110: dec_op[4] = 1'b1;
            4'b1011: dec_op[5] = 1'b1;
            4'b0101: dec_op[6] = 1'b1;
            4'b1010: begin
                if (f2 == '0)        dec_op[7] = 1'b1;
                else if (f2 == ONES) dec_op[8] = 1'b1;
                else                 dec_bad   = 1'b1;
            end
            4'b0011: begin
                if (f2 == RF_W'(0))      dec_op[9]  = 1'b1;
                else if (f2 == RF_W'(1)) dec_op[10] = 1'b1;
                else if (f2 == RF_W'(2)) dec_op[11] = 1'b1;
                else                     dec_bad    = 1'b1;
            end
            4'b0010: dec_op[12] = 1'b1;
            4'b0100: dec_op[13] = 1'b1;
            4'b0111: dec_op[14] = 1'b1;
            4'b1000: dec_op[15] = 1'b1;
            default: dec_bad = 1'b1;
        endcase
    end

`ifdef DEC_ILLEGAL_TRAP_EN
    assign nxt_op  = dec_op;
    assign nxt_ill = dec_bad;
`else
    // Undefined encodings are squashed to a harmless NOP
    assign nxt_op  = dec_bad ? 16'h4000 : dec_op;
    assign nxt_ill = 1'b0;
`endif

    assign in_ready = (state_q == RUN) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign halted   = (state_q != RUN);

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            flush:                  state_d = RUN;
            accept && nxt_op[15]:   state_d = HALTED;
`ifdef DEC_ILLEGAL_TRAP_EN
            accept && nxt_ill:      state_d = TRAPPED;
`endif
            default:                state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            op        <= '0;
            r1        <= '0;
            r2        <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            op        <= '0;
            r1        <= '0;
            r2        <= '0;
            illegal   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            op        <= nxt_op;
            r1        <= f1;
            r2        <= f2;
            illegal   <= nxt_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            op        <= '0;
            r1        <= '0;
            r2        <= '0;
            illegal   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode table plus handshake/halt/reset sequences.
// Expected values for illegal words follow DEC_ILLEGAL_TRAP_EN.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  ir = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] op;
    logic [1:0]  r1, r2;
    logic        illegal, halted;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [11:0] w_ir = '0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b1;
    logic [15:0] w_op;
    logic [2:0]  w_r1, w_r2;
    logic        w_illegal, w_halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .ir(ir),
        .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .r1(r1), .r2(r2),
        .illegal(illegal), .halted(halted)
    );

    instr_decode_stage #(.IR_W(12), .RF_W(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .ir(w_ir),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .op(w_op), .r1(w_r1), .r2(w_r2),
        .illegal(w_illegal), .halted(w_halted)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  w;
        logic [15:0] eop;
        logic        eill;
        logic [1:0]  er1;
        logic [1:0]  er2;
        logic        ehalt;
    } vec_t;

    vec_t vt[22];

`ifdef DEC_ILLEGAL_TRAP_EN
    localparam logic [15:0] BAD_OP  = 16'h0000;
    localparam logic        BAD_ILL = 1'b1;
    localparam logic        BAD_HLT = 1'b1;
`else
    localparam logic [15:0] BAD_OP  = 16'h4000;
    localparam logic        BAD_ILL = 1'b0;
    localparam logic        BAD_HLT = 1'b0;
`endif

    initial begin
        vt[0]  = '{8'hC0, 16'h0001, 1'b0, 2'd0, 2'd0, 1'b0};
        vt[1]  = '{8'hC3, 16'h0004, 1'b0, 2'd0, 2'd3, 1'b0};
        vt[2]  = '{8'hCC, 16'h0002, 1'b0, 2'd3, 2'd0, 1'b0};
        vt[3]  = '{8'h95, 16'h0008, 1'b0, 2'd1, 2'd1, 1'b0};
        vt[4]  = '{8'h6A, 16'h0010, 1'b0, 2'd2, 2'd2, 1'b0};
        vt[5]  = '{8'hB1, 16'h0020, 1'b0, 2'd0, 2'd1, 1'b0};
        vt[6]  = '{8'h54, 16'h0040, 1'b0, 2'd1, 2'd0, 1'b0};
        vt[7]  = '{8'hA0, 16'h0080, 1'b0, 2'd0, 2'd0, 1'b0};
        vt[8]  = '{8'hA3, 16'h0100, 1'b0, 2'd0, 2'd3, 1'b0};
        vt[9]  = '{8'h30, 16'h0200, 1'b0, 2'd0, 2'd0, 1'b0};
        vt[10] = '{8'h35, 16'h0400, 1'b0, 2'd1, 2'd1, 1'b0};
        vt[11] = '{8'h3A, 16'h0800, 1'b0, 2'd2, 2'd2, 1'b0};
        vt[12] = '{8'h20, 16'h1000, 1'b0, 2'd0, 2'd0, 1'b0};
        vt[13] = '{8'h40, 16'h2000, 1'b0, 2'd0, 2'd0, 1'b0};
        vt[14] = '{8'h7D, 16'h4000, 1'b0, 2'd3, 2'd1, 1'b0};
        vt[15] = '{8'h80, 16'h8000, 1'b0, 2'd0, 2'd0, 1'b1};
        vt[16] = '{8'hA1, BAD_OP, BAD_ILL, 2'd0, 2'd1, BAD_HLT};
        vt[17] = '{8'hF0, BAD_OP, BAD_ILL, 2'd0, 2'd0, BAD_HLT};
        vt[18] = '{8'h3B, BAD_OP, BAD_ILL, 2'd2, 2'd3, BAD_HLT};
        vt[19] = '{8'h00, BAD_OP, BAD_ILL, 2'd0, 2'd0, BAD_HLT};
        vt[20] = '{8'h1E, BAD_OP, BAD_ILL, 2'd3, 2'd2, BAD_HLT};
        vt[21] = '{8'hD5, BAD_OP, BAD_ILL, 2'd1, 2'd1, BAD_HLT};

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // table: one word each, flushed back to RUN afterwards
        out_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            in_valid = 1'b1;
            ir = vt[i].w;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("tbl%0d_op", i), 32'(op), 32'(vt[i].eop));
            chk($sformatf("tbl%0d_ill", i), 32'(illegal), 32'(vt[i].eill));
            chk($sformatf("tbl%0d_r1", i), 32'(r1), 32'(vt[i].er1));
            chk($sformatf("tbl%0d_r2", i), 32'(r2), 32'(vt[i].er2));
            chk($sformatf("tbl%0d_halt", i), 32'(halted), 32'(vt[i].ehalt));
            flush = 1'b1;
            tick();
            flush = 1'b0;
            chk($sformatf("tbl%0d_flush_valid", i), 32'(out_valid), 32'd0);
            chk($sformatf("tbl%0d_flush_halt", i), 32'(halted), 32'd0);
        end

        // back-to-back stream at one word per cycle
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                in_valid = 1'b1;
                ir = vt[i].w;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk($sformatf("str%0d_in_ready", i), 32'(in_ready), 32'd1);
            if (i > 0) chk($sformatf("str%0d_op", i), 32'(op), 32'(vt[i-1].eop));
            tick();
        end
        chk("str_drain", 32'(out_valid), 32'd0);

        // backpressure: JZ held, then JC
        out_ready = 1'b0;
        in_valid = 1'b1;
        ir = 8'h35;
        tick();
        ir = 8'h3A;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_op", i), 32'(op), 32'h0400);
            chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_jc_op", 32'(op), 32'h0800);
        chk("bp_jc_r2", 32'(r2), 32'd2);
        tick();
        chk("bp_empty_valid", 32'(out_valid), 32'd0);
        chk("bp_empty_op", 32'(op), 32'd0);

        // flush refuses a simultaneous word
        in_valid = 1'b1;
        ir = 8'h95;
        flush = 1'b1;
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_refused", 32'(out_valid), 32'd0);

        // HALT: delivered once, then stuck until flush
        in_valid = 1'b1;
        ir = 8'h80;
        tick();
        chk("h_op", 32'(op), 32'h8000);
        chk("h_halted", 32'(halted), 32'd1);
        chk("h_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("h_once", 32'(out_valid), 32'd0);
        chk("h_stuck", 32'(halted), 32'd1);
        chk("h_stuck_ready", 32'(in_ready), 32'd0);
        tick();
        chk("h_still", 32'(out_valid), 32'd0);
        flush = 1'b1;
        in_valid = 1'b0;
        tick();
        flush = 1'b0;
        #1;
        chk("h_release", 32'(halted), 32'd0);
        chk("h_release_ready", 32'(in_ready), 32'd1);

        // wide build: IR_W=12, RF_W=3
        w_in_valid = 1'b1;
        w_ir = 12'hC07;
        tick();
        w_ir = 12'hA38;
        chk("w_movc", 32'(w_op), 32'h0004);
        chk("w_movc_r2", 32'(w_r2), 32'd7);
        tick();
        w_ir = 12'hA3F;
        chk("w_rsr", 32'(w_op), 32'h0080);
        chk("w_rsr_r1", 32'(w_r1), 32'd7);
        chk("w_rsr_r2", 32'(w_r2), 32'd0);
        tick();
        w_in_valid = 1'b0;
        chk("w_rsl", 32'(w_op), 32'h0100);
        chk("w_rsl_ill", 32'(w_illegal), 32'd0);

        // asynchronous reset while a HALT result is stalled
        out_ready = 1'b0;
        in_valid = 1'b1;
        ir = 8'h80;
        tick();
        in_valid = 1'b0;
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        chk("ar_pre_halt", 32'(halted), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_op", 32'(op), 32'd0);
        chk("ar_halt", 32'(halted), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered, parametrised successor to the combinational opcode decoder; sits between the fetch register and the control-signal generator.
- Accepts one instruction word per cycle over a valid/ready handshake.
- Decodes it into a 16-bit one-hot control vector plus register fields, and holds the result in an output pipeline register.
- Adds illegal-opcode detection, a sticky HALT state, and a flush input.

Parameters:
- IR_W, 8, instruction word width; must be >= 4 + 2*RF_W.
- RF_W, 2, width of each register/sub-op field (r1, r2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; clears the output register and returns the FSM to RUN.
- in_valid  in  1  instruction word on ir is valid.
- in_ready  out  1  stage can accept ir this cycle.
- ir  in  IR_W  instruction word.
- out_valid  out  1  decoded result held in output register.
- out_ready  in  1  downstream consumes the result this cycle.
- op  out  16  one-hot decode. Bit order 0..15: MOVA, MOVB, MOVC, ADD, SUB, AND, NOT, RSR, RSL, JMP, JZ, JC, IN, OUT, NOP, HALT.
- r1  out  RF_W  registered ir[2*RF_W-1:RF_W].
- r2  out  RF_W  registered ir[RF_W-1:0].
- illegal  out  1  registered; current result came from an undefined encoding.
- halted  out  1  FSM is in HALTED or TRAPPED.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, op=0, r1=0, r2=0, illegal=0, halted=0, FSM=RUN.
- Field split:
  - opc = ir[IR_W-1 -: 4].
  - Bits between opc and r1 are ignored.
  - ONES = all-ones RF_W value.
- Decode:
  - 1100: r2==ONES -> MOVC; else r1==ONES -> MOVB; else MOVA.
  - 1001 ADD; 0110 SUB; 1011 AND; 0101 NOT.
  - 1010: r2==0 -> RSR; r2==ONES -> RSL; else illegal.
  - 0011: r2==0 -> JMP; r2==1 -> JZ; r2==2 -> JC; else illegal.
  - 0010 IN; 0100 OUT; 0111 NOP; 1000 HALT.
  - 0000, 0001, 1101, 1110, 1111: illegal.
- Handshake:
  - in_ready = (FSM==RUN) && (!out_valid || out_ready) && !flush.
  - Accept = in_valid && in_ready.
  - On accept, the output register loads decode(ir), r1, r2, illegal, and out_valid=1 on the next edge.
  - Latency is 1 cycle.
  - If out_ready=1 and there is no accept, out_valid falls to 0.
  - Back-to-back accept with out_ready=1 sustains 1 instruction/cycle.
- Output rules:
  - While out_valid=1, op holds exactly one set bit, or all zero if illegal=1.
  - While out_valid=0, op=0 and illegal=0.
  - Outputs stay stable while out_valid=1 && out_ready=0.
- FSM:
  - RUN -> HALTED on accept of a HALT word. The HALT result itself is still presented downstream.
  - HALTED: in_ready=0; stays until flush.
  - TRAPPED: see Optional Feature.
  - flush (any state) -> RUN next edge, out_valid=0, halted=0. flush beats a simultaneous accept, which is refused since in_ready=0.
- Reset mid-transfer discards the held result immediately.

Optional Feature:
- Macro: DEC_ILLEGAL_TRAP_EN.
- Defined:
  - Accepting an illegal word presents it with illegal=1, op=0, and moves RUN -> TRAPPED.
  - TRAPPED behaves like HALTED: halted=1, in_ready=0, exit only via flush.
- Undefined:
  - Illegal words decode as NOP (op bit 14) with illegal=0.
  - The FSM never leaves RUN on them; the TRAPPED state does not exist.

Test Plan:
- Reset, then stream 0xC0, 0xC3, 0xCC, 0x9x with out_ready=1 -> op bits 0, 2, 1, 3 one cycle after each accept; in_ready held 1 throughout.
- Accept 0x35 then 0x3A with out_ready=0 for 3 cycles -> JZ held stable, in_ready=0 until out_ready=1, then JC delivered.
- Accept 0x80, keep in_valid=1 -> HALT (bit 15) output once, halted=1, in_ready=0; assert flush -> halted=0, in_ready=1 next cycle.
- Accept 0xA1 and 0xF0:
  - With DEC_ILLEGAL_TRAP_EN: illegal=1, op=0, halted=1.
  - Without: op=NOP, illegal=0, halted=0.
- Build with IR_W=12, RF_W=3; accept 0xC07 -> MOVC; accept 0xA38 -> RSR (r2=0); accept 0xA3F -> RSL.
- Assert rst_n=0 asynchronously while out_valid=1 and out_ready=0 -> out_valid, op, and halted drop without waiting for a clock edge.
